id_ex_stage: RTL

ID/EX pipeline stage of the pipelined RV32 core: captures decoded fields and register operands produced by `regfile` and the decoder, and presents them registered to execute. It owns load-use hazard detection (stall plus bubble), WB→ID write bypass for the same-cycle regfile write, flush from execute, and a stall-cycle counter. It sits between decode/`regfile` and the execute stage.

---
 rtl/all_pkgs.sv | 23 ++
 rtl/id_hazard_unit.sv | 29 ++
 rtl/id_ex_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/all_pkgs.sv
// Shared core package.
// Contents:
//   WIDTH     datapath width of the RV32 core
//   ctrl_t    decoded control bundle carried from decode to execute
//   CTRL_NOP  control value of a bubble / empty slot (all zeros)
package all_pkgs;

    localparam int WIDTH = 32;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src_imm;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;
        logic       reg_write;
        logic       branch;
        logic       jump;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_hazard_unit.sv
// Load-use hazard detector (combinational).
// Flags when the instruction in EX is a load whose destination is read by
// the valid instruction waiting in ID. x0 never creates a hazard.
// Ports:
//   ex_valid_i, ex_mem_read_i, ex_rd_addr_i      state of the EX slot
//   id_valid_i, id_uses_rs1/2_i, id_rs1/2_addr_i  operand usage of ID
//   hazard_o                                      stall ID one cycle
module id_hazard_unit (
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic       id_valid_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    output logic       hazard_o
);

    logic rs1_dep;
    logic rs2_dep;

    assign rs1_dep  = id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i);
    assign rs2_dep  = id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i);

    assign hazard_o = ex_valid_i && ex_mem_read_i && (ex_rd_addr_i != 5'd0) &&
                      id_valid_i && (rs1_dep || rs2_dep);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV32 core.
// Captures decoded fields and regfile operands and presents them to execute.
// Handles load-use stall (one bubble), same-cycle WB->ID bypass, operand
// refresh while EX is stalled, flush from execute and a bubble counter.
// Ports:
//   clk, rst                          core clock, synchronous active-high reset
//   id_*                              decode-side instruction and operands
//   id_ready                          decode instruction accepted (combinational)
//   wb_wr_en, wb_rd_addr, wb_rd_data  regfile write happening this cycle
//   flush                             execute redirect, kills EX and ID
//   ex_ready                          execute consumes the EX slot
//   ex_*                              registered EX slot
//   bubble_cnt                        load-use bubbles inserted (saturating)
module id_ex_stage
    import all_pkgs::*;
#(
    parameter int WIDTH = all_pkgs::WIDTH,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [WIDTH-1:0] id_pc,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [WIDTH-1:0] id_rs1_data,
    input  logic [WIDTH-1:0] id_rs2_data,
    input  logic [WIDTH-1:0] id_imm,
    input  ctrl_t            id_ctrl,
    input  logic             wb_wr_en,
    input  logic [4:0]       wb_rd_addr,
    input  logic [WIDTH-1:0] wb_rd_data,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_pc,
    output logic [WIDTH-1:0] ex_rs1_val,
    output logic [WIDTH-1:0] ex_rs2_val,
    output logic [WIDTH-1:0] ex_imm,
    output logic [4:0]       ex_rs1_addr,
    output logic [4:0]       ex_rs2_addr,
    output logic [4:0]       ex_rd_addr,
    output ctrl_t            ex_ctrl,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic             valid_q,   valid_d;
    logic [WIDTH-1:0] pc_q,      pc_d;
    logic [WIDTH-1:0] rs1_val_q, rs1_val_d;
    logic [WIDTH-1:0] rs2_val_q, rs2_val_d;
    logic [WIDTH-1:0] imm_q,     imm_d;
    logic [4:0]       rs1_addr_q, rs1_addr_d;
    logic [4:0]       rs2_addr_q, rs2_addr_d;
    logic [4:0]       rd_addr_q,  rd_addr_d;
    ctrl_t            ctrl_q,    ctrl_d;
    logic [CNT_W-1:0] bub_q,     bub_d;

    logic             advance;
    logic             hazard;
    logic             wb_live;
    logic [WIDTH-1:0] rs1_byp;
    logic [WIDTH-1:0] rs2_byp;

    id_hazard_unit u_hazard (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rd_addr_i  (rd_addr_q),
        .id_valid_i    (id_valid),
        .id_uses_rs1_i (id_uses_rs1),
        .id_uses_rs2_i (id_uses_rs2),
        .id_rs1_addr_i (id_rs1_addr),
        .id_rs2_addr_i (id_rs2_addr),
        .hazard_o      (hazard)
    );

    assign advance = !valid_q || ex_ready;

    // The regfile read is asynchronous and misses the write landing this
    // cycle, so the writeback value is taken directly.
    assign wb_live = wb_wr_en && (wb_rd_addr != 5'd0);
    assign rs1_byp = (wb_live && wb_rd_addr == id_rs1_addr) ? wb_rd_data : id_rs1_data;
    assign rs2_byp = (wb_live && wb_rd_addr == id_rs2_addr) ? wb_rd_data : id_rs2_data;

    assign id_ready = flush || (advance && !hazard);

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_val_d  = rs1_val_q;
        rs2_val_d  = rs2_val_q;
        imm_d      = imm_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_addr_d  = rd_addr_q;
        ctrl_d     = ctrl_q;
        bub_d      = bub_q;

        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
        end else if (advance && hazard) begin
            // Data fields keep their old values; only valid/ctrl are cleared.
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
            if (bub_q != '1) begin
                bub_d = bub_q + CNT_W'(1);
            end
        end else if (advance) begin
            valid_d    = id_valid;
            pc_d       = id_pc;
            rs1_val_d  = rs1_byp;
            rs2_val_d  = rs2_byp;
            imm_d      = id_imm;
            rs1_addr_d = id_rs1_addr;
            rs2_addr_d = id_rs2_addr;
            rd_addr_d  = id_rd_addr;
            ctrl_d     = id_ctrl;
        end else begin
            // EX stalled: a held operand would go stale if its register is
            // written back meanwhile, so track the write.
            if (wb_live && wb_rd_addr == rs1_addr_q) begin
                rs1_val_d = wb_rd_data;
            end
            if (wb_live && wb_rd_addr == rs2_addr_q) begin
                rs2_val_d = wb_rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_val_q  <= '0;
            rs2_val_q  <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            ctrl_q     <= CTRL_NOP;
            bub_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_val_q  <= rs1_val_d;
            rs2_val_q  <= rs2_val_d;
            imm_q      <= imm_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_addr_q  <= rd_addr_d;
            ctrl_q     <= ctrl_d;
            bub_q      <= bub_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_rs1_val  = rs1_val_q;
    assign ex_rs2_val  = rs2_val_q;
    assign ex_imm      = imm_q;
    assign ex_rs1_addr = rs1_addr_q;
    assign ex_rs2_addr = rs2_addr_q;
    assign ex_rd_addr  = rd_addr_q;
    assign ex_ctrl     = ctrl_q;
    assign bubble_cnt  = bub_q;

endmodule
